// File: rtl/snoop_response_ctrl_if.sv
// Snoop response controller bus bundle: snoop intake, tag lookup,
// writeback, line-state update, result and status signals.
interface snoop_response_ctrl_if #(
  parameter int ADDRESS_SIZE = 32
);
  logic                    snp_valid;
  logic [2:0]              snp_op;
  logic [ADDRESS_SIZE-1:0] snp_addr;
  logic                    snp_ready;

  logic                    lkup_req;
  logic [ADDRESS_SIZE-1:0] lkup_addr;
  logic                    lkup_ack;
  logic                    lkup_hit;
  logic [1:0]              lkup_mesi;

  logic                    wb_req;
  logic [ADDRESS_SIZE-1:0] wb_addr;
  logic                    wb_ack;

  logic                    upd_valid;
  logic [ADDRESS_SIZE-1:0] upd_addr;
  logic [1:0]              upd_mesi;

  logic                    res_valid;
  logic [ADDRESS_SIZE-1:0] res_addr;
  logic [1:0]              res_result;

  logic                    err_proto;
  logic                    err_timeout;
  logic [15:0]             snoop_cnt;

  modport slave (
    input  snp_valid, snp_op, snp_addr,
    output snp_ready,
    output lkup_req, lkup_addr,
    input  lkup_ack, lkup_hit, lkup_mesi,
    output wb_req, wb_addr,
    input  wb_ack,
    output upd_valid, upd_addr, upd_mesi,
    output res_valid, res_addr, res_result,
    output err_proto, err_timeout, snoop_cnt
  );

  modport master (
    output snp_valid, snp_op, snp_addr,
    input  snp_ready,
    input  lkup_req, lkup_addr,
    output lkup_ack, lkup_hit, lkup_mesi,
    input  wb_req, wb_addr,
    output wb_ack,
    input  upd_valid, upd_addr, upd_mesi,
    input  res_valid, res_addr, res_result,
    input  err_proto, err_timeout, snoop_cnt
  );
endinterface

// File: rtl/snoop_response_ctrl.sv
// Snoop response controller: looks up a snooped line, flushes modified
// data, updates the MESI state and reports HIT/HITM/NOHIT.
module snoop_response_ctrl #(
  parameter int ADDRESS_SIZE = 32,
  parameter int TIMEOUT      = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  snoop_response_ctrl_if.slave bus
);

  localparam logic [2:0] OP_READ = 3'd1;
  localparam logic [2:0] OP_INV  = 3'd3;
  localparam logic [2:0] OP_RWIM = 3'd4;

  localparam logic [1:0] M_I = 2'd0;
  localparam logic [1:0] M_S = 2'd1;
  localparam logic [1:0] M_E = 2'd2;
  localparam logic [1:0] M_M = 2'd3;

  localparam logic [1:0] R_HIT   = 2'd0;
  localparam logic [1:0] R_HITM  = 2'd1;
  localparam logic [1:0] R_NOHIT = 2'd2;

  localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    WB,
    RESP
  } state_t;

  typedef struct packed {
    logic [1:0] res;
    logic       wb;
    logic       upd;
    logic [1:0] mesi;
    logic       perr;
  } dec_t;

  state_t                  state;
  logic [2:0]              op_q;
  logic [ADDRESS_SIZE-1:0] addr_q;
  logic [7:0]              tcnt;
  logic [1:0]              pend_mesi;
  dec_t                    lk_dec;
  logic                    is_lkup;

  function automatic dec_t decode(
    input logic [2:0] op,
    input logic       hit,
    input logic [1:0] mesi_in
  );
    dec_t       d;
    logic [1:0] st;
    st = hit ? mesi_in : M_I;
    d  = '{res: R_NOHIT, wb: 1'b0, upd: 1'b0,
           mesi: M_I, perr: 1'b0};
    unique case (1'b1)
      op == OP_READ: begin
        case (st)
          M_M: d = '{R_HITM, 1'b1, 1'b1, M_S, 1'b0};
          M_E: d = '{R_HIT, 1'b0, 1'b1, M_S, 1'b0};
          M_S: d = '{R_HIT, 1'b0, 1'b0, M_I, 1'b0};
          default: ;
        endcase
      end
      op == OP_RWIM: begin
        case (st)
          M_M: d = '{R_HITM, 1'b1, 1'b1, M_I, 1'b0};
          M_E,
          M_S: d = '{R_HIT, 1'b0, 1'b1, M_I, 1'b0};
          default: ;
        endcase
      end
      op == OP_INV: begin
        // Exclusive/modified lines must not see an INVALIDATE
        case (st)
          M_S: d = '{R_HIT, 1'b0, 1'b1, M_I, 1'b0};
          M_E,
          M_M: d.perr = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
    return d;
  endfunction

  assign lk_dec  = decode(op_q, bus.lkup_hit, bus.lkup_mesi);
  assign is_lkup = (bus.snp_op == OP_READ) ||
                   (bus.snp_op == OP_INV)  ||
                   (bus.snp_op == OP_RWIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      op_q            <= '0;
      addr_q          <= '0;
      tcnt            <= '0;
      pend_mesi       <= M_I;
      bus.snp_ready   <= 1'b0;
      bus.lkup_req    <= 1'b0;
      bus.lkup_addr   <= '0;
      bus.wb_req      <= 1'b0;
      bus.wb_addr     <= '0;
      bus.upd_valid   <= 1'b0;
      bus.upd_addr    <= '0;
      bus.upd_mesi    <= M_I;
      bus.res_valid   <= 1'b0;
      bus.res_addr    <= '0;
      bus.res_result  <= R_NOHIT;
      bus.err_proto   <= 1'b0;
      bus.err_timeout <= 1'b0;
      bus.snoop_cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.snp_valid && bus.snp_ready) begin
            bus.snp_ready <= 1'b0;
            op_q          <= bus.snp_op;
            addr_q        <= bus.snp_addr;
            if (is_lkup) begin
              state         <= LOOKUP;
              tcnt          <= '0;
              bus.lkup_req  <= 1'b1;
              bus.lkup_addr <= bus.snp_addr;
            end else begin
              state          <= RESP;
              bus.res_valid  <= 1'b1;
              bus.res_addr   <= bus.snp_addr;
              bus.res_result <= R_NOHIT;
              bus.snoop_cnt  <= bus.snoop_cnt + 16'd1;
            end
          end else begin
            bus.snp_ready <= 1'b1;
          end
        end

        LOOKUP: begin
          // An ack in the expiry cycle still takes priority
          if (bus.lkup_ack) begin
            bus.lkup_req  <= 1'b0;
            bus.lkup_addr <= '0;
            pend_mesi     <= lk_dec.mesi;
            if (lk_dec.perr) begin
              bus.err_proto <= 1'b1;
            end
            if (lk_dec.wb) begin
              state       <= WB;
              bus.wb_req  <= 1'b1;
              bus.wb_addr <= addr_q;
            end else begin
              state          <= RESP;
              bus.res_valid  <= 1'b1;
              bus.res_addr   <= addr_q;
              bus.res_result <= lk_dec.res;
              bus.upd_valid  <= lk_dec.upd;
              bus.upd_addr   <= lk_dec.upd ? addr_q : '0;
              bus.upd_mesi   <= lk_dec.upd ? lk_dec.mesi : M_I;
              bus.snoop_cnt  <= bus.snoop_cnt + 16'd1;
            end
          end else if (tcnt == TMAX) begin
            state           <= RESP;
            bus.lkup_req    <= 1'b0;
            bus.lkup_addr   <= '0;
            bus.err_timeout <= 1'b1;
            bus.res_valid   <= 1'b1;
            bus.res_addr    <= addr_q;
            bus.res_result  <= R_NOHIT;
            bus.snoop_cnt   <= bus.snoop_cnt + 16'd1;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end

        WB: begin
          // Only modified hits reach here, so the answer is always HITM
          if (bus.wb_ack) begin
            state          <= RESP;
            bus.wb_req     <= 1'b0;
            bus.wb_addr    <= '0;
            bus.res_valid  <= 1'b1;
            bus.res_addr   <= addr_q;
            bus.res_result <= R_HITM;
            bus.upd_valid  <= 1'b1;
            bus.upd_addr   <= addr_q;
            bus.upd_mesi   <= pend_mesi;
            bus.snoop_cnt  <= bus.snoop_cnt + 16'd1;
          end
        end

        RESP: begin
          state         <= IDLE;
          bus.res_valid <= 1'b0;
          bus.res_addr  <= '0;
          bus.upd_valid <= 1'b0;
          bus.upd_addr  <= '0;
          bus.upd_mesi  <= M_I;
          bus.snp_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snoop_response_ctrl.sv
// Randomized scoreboard bench for snoop_response_ctrl with a
// table-driven reference model of the snoop protocol.
module tb_snoop_response_ctrl;

  localparam int AW = 32;
  localparam int T  = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  snoop_response_ctrl_if #(.ADDRESS_SIZE(AW)) bus();

  snoop_response_ctrl #(
    .ADDRESS_SIZE(AW),
    .TIMEOUT(T)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  res;
    logic        upd;
    logic [1:0]  mesi;
    int          at;
    logic        ep;
    logic        et;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   checks = 0;
  int   passes = 0;
  int   m_cnt = 0;
  logic m_perr = 1'b0;
  logic m_tout = 1'b0;

  // Reference tables indexed [op][line state]
  logic [1:0] t_res  [8][4];
  logic       t_upd  [8][4];
  logic [1:0] t_new  [8][4];
  logic       t_wb   [8][4];
  logic       t_perr [8][4];

  task automatic check(input string name, input longint act,
                       input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h",
                  name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.res_valid) begin
        if (q.size() == 0) begin
          check("unexpected_res", 1, 0);
        end else begin
          me = q.pop_front();
          m_cnt = (m_cnt + 1) % 65536;
          check("res_addr", bus.res_addr, me.addr);
          check("res_result", bus.res_result, me.res);
          check("upd_valid", bus.upd_valid, me.upd);
          if (me.upd) begin
            check("upd_mesi", bus.upd_mesi, me.mesi);
            check("upd_addr", bus.upd_addr, me.addr);
          end
          check("res_cycle", cyc, me.at);
          check("snoop_cnt", bus.snoop_cnt, m_cnt);
          check("err_proto", bus.err_proto, me.ep);
          check("err_timeout", bus.err_timeout, me.et);
        end
      end else if (bus.upd_valid) begin
        check("upd_without_res", 1, 0);
      end
    end
  end

  task automatic snoop(input logic [2:0] op, input logic [31:0] addr,
                       input logic hit, input logic [1:0] mesi,
                       input int k, input int j);
    int   a;
    int   n;
    int   st;
    bit   look;
    exp_t e;
    n = 0;
    while (!bus.snp_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.snp_ready) begin
      check("ready_wait", 0, 1);
      return;
    end
    bus.snp_valid = 1'b1;
    bus.snp_op    = op;
    bus.snp_addr  = addr;
    @(posedge clk);
    #1 a = cyc;
    look = (op == 3'd1) || (op == 3'd3) || (op == 3'd4);
    st   = hit ? int'(mesi) : 0;
    e.addr = addr;
    e.res  = 2'd2;
    e.upd  = 1'b0;
    e.mesi = 2'd0;
    e.at   = a;
    if (look && k > T) begin
      m_tout = 1'b1;
      e.at   = a + T;
    end else if (look) begin
      e.res  = t_res[op][st];
      e.upd  = t_upd[op][st];
      e.mesi = t_new[op][st];
      e.at   = a + k + (t_wb[op][st] ? j : 0);
      if (t_perr[op][st]) m_perr = 1'b1;
    end
    e.ep = m_perr;
    e.et = m_tout;
    q.push_back(e);
    @(negedge clk);
    bus.snp_valid = 1'b0;
    bus.snp_op    = 3'($urandom);
    if (!look) begin
      check("no_lkup_req", bus.lkup_req, 0);
      bus.lkup_ack  = 1'b1;
      bus.wb_ack    = 1'b1;
      bus.lkup_hit  = 1'b1;
      bus.lkup_mesi = 2'd3;
      @(negedge clk);
      bus.lkup_ack = 1'b0;
      bus.wb_ack   = 1'b0;
    end else begin
      check("lkup_req", bus.lkup_req, 1);
      check("lkup_addr", bus.lkup_addr, addr);
      if (k > T) begin
        repeat (T) @(negedge clk);
      end else begin
        repeat (k - 1) @(negedge clk);
        bus.lkup_ack  = 1'b1;
        bus.lkup_hit  = hit;
        bus.lkup_mesi = mesi;
        @(negedge clk);
        bus.lkup_ack  = 1'b0;
        bus.lkup_hit  = 1'($urandom);
        bus.lkup_mesi = 2'($urandom);
        if (t_wb[op][st]) begin
          check("wb_req", bus.wb_req, 1);
          check("wb_addr", bus.wb_addr, addr);
          repeat (j - 1) @(negedge clk);
          bus.wb_ack = 1'b1;
          @(negedge clk);
          bus.wb_ack = 1'b0;
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_snp_ready"}, bus.snp_ready, 0);
    check({tag, "_reqs"},
          {bus.lkup_req, bus.wb_req, bus.upd_valid, bus.res_valid}, 0);
    check({tag, "_addrs"},
          bus.lkup_addr | bus.wb_addr | bus.upd_addr | bus.res_addr, 0);
    check({tag, "_upd_mesi"}, bus.upd_mesi, 0);
    check({tag, "_res_result"}, bus.res_result, 2);
    check({tag, "_errs"}, {bus.err_proto, bus.err_timeout}, 0);
    check({tag, "_cnt"}, bus.snoop_cnt, 0);
  endtask

  initial begin
    int r;
    int k;
    int n;
    for (int o = 0; o < 8; o++) begin
      for (int s = 0; s < 4; s++) begin
        t_res[o][s]  = 2'd2;
        t_upd[o][s]  = 1'b0;
        t_new[o][s]  = 2'd0;
        t_wb[o][s]   = 1'b0;
        t_perr[o][s] = 1'b0;
      end
    end
    t_res[1][3] = 2'd1; t_wb[1][3] = 1; t_upd[1][3] = 1; t_new[1][3] = 2'd1;
    t_res[1][2] = 2'd0; t_upd[1][2] = 1; t_new[1][2] = 2'd1;
    t_res[1][1] = 2'd0;
    t_res[4][3] = 2'd1; t_wb[4][3] = 1; t_upd[4][3] = 1;
    t_res[4][2] = 2'd0; t_upd[4][2] = 1;
    t_res[4][1] = 2'd0; t_upd[4][1] = 1;
    t_res[3][1] = 2'd0; t_upd[3][1] = 1;
    t_perr[3][2] = 1;
    t_perr[3][3] = 1;

    bus.snp_valid = 1'b0;
    bus.snp_op    = 3'd0;
    bus.snp_addr  = '0;
    bus.lkup_ack  = 1'b0;
    bus.lkup_hit  = 1'b0;
    bus.lkup_mesi = 2'd0;
    bus.wb_ack    = 1'b0;

    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_before_edge", bus.snp_ready, 0);
    @(negedge clk);
    check("ready_after_edge", bus.snp_ready, 1);

    snoop(3'd1, 32'h1000, 1'b1, 2'd3, 2, 3);
    snoop(3'd4, 32'h2040, 1'b1, 2'd2, 1, 1);
    snoop(3'd3, 32'h2480, 1'b1, 2'd3, 3, 1);
    snoop(3'd2, 32'h3000, 1'b0, 2'd0, 1, 1);
    snoop(3'd1, 32'h4000, 1'b1, 2'd2, T, 1);
    snoop(3'd1, 32'h4040, 1'b1, 2'd3, T + 1, 1);

    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) k = T;
      else if (r == 1) k = T + $urandom_range(1, 4);
      else k = $urandom_range(1, 4);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      snoop(3'($urandom), $urandom, 1'($urandom), 2'($urandom),
            k, $urandom_range(1, 4));
    end

    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", q.size(), 0);

    // Reset while a modified-line flush is pending
    while (!bus.snp_ready) @(negedge clk);
    bus.snp_valid = 1'b1;
    bus.snp_op    = 3'd1;
    bus.snp_addr  = 32'h5000;
    @(negedge clk);
    bus.snp_valid = 1'b0;
    bus.lkup_ack  = 1'b1;
    bus.lkup_hit  = 1'b1;
    bus.lkup_mesi = 2'd3;
    @(negedge clk);
    bus.lkup_ack = 1'b0;
    check("wb_before_reset", bus.wb_req, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midwb");
    m_cnt  = 0;
    m_perr = 1'b0;
    m_tout = 1'b0;
    bus.wb_ack = 1'b1;
    repeat (2) @(negedge clk);
    bus.wb_ack = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_res", bus.res_valid, 0);
    check("post_reset_ready", bus.snp_ready, 1);
    snoop(3'd2, 32'h6000, 1'b0, 2'd0, 1, 1);
    repeat (3) @(negedge clk);
    check("final_queue", q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

endmodule
